io_read_bus: RTL and testbench
==============================

# io_read_bus

Parametrised, registered I/O read collector for the Minisys-1A memory/IO path. It replaces the ad-hoc per-device read mux between the memorio address decoder and peripherals such as switches, keyboard and timer. It supports NCH channels, per-channel wait states, and a defined priority rule for overlapping chip selects. Each completed read produces a one-cycle valid pulse and a per-channel read strobe, so clear-on-read devices can acknowledge the access.

## Interface
- NCH, 4, number of peripheral channels (1..16)
- DW, 16, data width per channel
- WW, 3, width of each wait-state field
- WAIT_CFG, 0, packed NCH*WW vector; field i (bits i*WW +: WW) is wait cycles for channel i
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- rd_req  input  1  read request, sampled only when busy=0
- cs  input  NCH  chip selects from address decode, sampled with rd_req
- ch_data  input  NCH*DW  packed channel read data, channel i at bits i*DW +: DW
- err_clr  input  1  clears err_sticky
- rd_data  output  DW  captured read data, held until next capture
- rd_valid  output  1  one-cycle pulse, rd_data updated this cycle
- busy  output  1  high while in WAIT state; rd_req ignored
- ch_rd_strobe  output  NCH  one-hot one-cycle pulse for the channel read, coincident with rd_valid
- err_nosel  output  1  pulse with rd_valid: request had cs==0
- err_multi  output  1  pulse with rd_valid: request had more than one cs bit set
- err_sticky  output  1  set by any err pulse, cleared by err_clr or reset

## Operation
- States: IDLE, WAIT. Reset sets state to IDLE and clears every output, including rd_data.
- Accept: the block accepts a request when it is in IDLE and rd_req=1.
  - On accept, latch sel_q, which is the index of the lowest set bit of cs.
  - On accept, latch the multi flag and the nosel flag.
  - On accept, look up w = WAIT_CFG[sel_q].
- w==0: capture at the accept edge and stay in IDLE.
- w>0: go to WAIT with cnt=w. Each WAIT cycle decrements cnt. When cnt==1, capture at that edge and return to IDLE.
- Capture:
  - rd_data takes the live ch_data[sel_q] at the capture edge.
  - rd_valid, ch_rd_strobe[sel_q] and the error pulses assert for the following cycle.
- nosel capture:
  - rd_data=0 and ch_rd_strobe=0.
  - err_nosel=1 and rd_valid=1.
  - Wait is forced to 0.
- multi: the lowest index wins, and the wait and strobe follow that channel. err_multi=1.
- err_sticky: the set condition wins over err_clr in the same cycle.
- rd_req while busy: ignored, no queuing. rd_req held high in IDLE issues a new read every completion.

## Timing
- Latency from accept edge to rd_valid high:
  - 1 cycle when w=0.
  - 1+w cycles when w>0.
- Throughput: one read per cycle when w=0. A read every w+1 cycles otherwise, because the IDLE accept cycle adds one cycle between reads.
- busy is high for exactly w cycles after accept. It is registered and goes low in the cycle rd_valid rises.
- cs/ch_data timing:
  - cs is sampled only at the accept edge.
  - ch_data is sampled only at the capture edge; it may change during WAIT.
- Reset mid-WAIT: the next cycle is IDLE, all pulses are 0, no strobe is issued, and rd_data=0.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared header io_read_defs.vh:
  - state encodings ST_IDLE/ST_WAIT
  - default DW
  - macro for extracting a packed field
- Sub-module io_prio_enc (parameter N):
  - input vec[N]
  - outputs idx[$clog2(N)], none, multi
  - purely combinational
  - reused by future interrupt logic
- Top-level io_read_bus contains:
  - the FSM
  - the wait counter (WW bits)
  - sel_q and the flag registers
  - the output registers

## Test plan
- Default WAIT_CFG=0, NCH=4. cs=0010, ch1=16'hA5A5, one-cycle rd_req -> next cycle rd_valid=1, rd_data=A5A5, ch_rd_strobe=0010, busy never high.
- WAIT_CFG ch2=3. cs=0100, ch2 changes 1111->2222 during WAIT -> busy high 3 cycles, rd_valid 4 cycles after accept, rd_data=2222, strobe=0100.
- cs=1010 -> channel 1 data returned, err_multi pulse, err_sticky=1. err_clr -> err_sticky=0.
- cs=0000 -> rd_valid next cycle, rd_data=0000, err_nosel=1, strobe=0000.
- ch0 w=2, rd_req held high -> valid every 3 cycles. A second rd_req pulse during busy -> no extra valid.
- Reset asserted one cycle into WAIT -> next cycle all outputs 0 and state IDLE. The post-reset read cs=0001 completes normally.

Source files
------------

// File: rtl/io_read_bus_pkg.sv
// Shared types and helpers for the I/O read collector: FSM state encoding,
// default data width, and index-width sizing.
package io_read_bus_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int DEFAULT_DW = 16;

  // Index width that stays at least one bit for single-channel builds.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_prio_enc.sv
// Lowest-index-wins priority encoder with none/multi flags; purely combinational.
// Zero latency, no flow control.
module io_prio_enc
  import io_read_bus_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]            vec,
  output logic [idx_width(N)-1:0] idx,
  output logic                    none,
  output logic                    multi
);

  localparam int IW = idx_width(N);

  always_comb begin
    idx   = '0;
    none  = (vec == '0);
    // Clearing the lowest set bit leaves something only if two or more were set.
    multi = ((vec & (vec - N'(1))) != '0);
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = IW'(i);
    end
  end

endmodule

// File: rtl/io_read_bus.sv
// Registered I/O read collector: priority-selects a channel, waits its configured
// cycles, captures data. Latency 1+w cycles; requests arriving while busy are dropped.
module io_read_bus
  import io_read_bus_pkg::*;
#(
  parameter int                NCH      = 4,
  parameter int                DW       = DEFAULT_DW,
  parameter int                WW       = 3,
  parameter logic [NCH*WW-1:0] WAIT_CFG = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [NCH-1:0]    cs,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic              err_clr,
  output logic [DW-1:0]     rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic [NCH-1:0]    ch_rd_strobe,
  output logic              err_nosel,
  output logic              err_multi,
  output logic              err_sticky
);

  localparam int IW = idx_width(NCH);

  state_e          state_q, state_d;
  logic [WW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   sel_q, sel_d;
  logic            nosel_q, nosel_d;
  logic            multi_q, multi_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            busy_q, busy_d;
  logic [NCH-1:0]  strobe_q, strobe_d;
  logic            err_nosel_q, err_nosel_d;
  logic            err_multi_q, err_multi_d;
  logic            err_sticky_q, err_sticky_d;

  logic [IW-1:0]   enc_idx;
  logic            enc_none;
  logic            enc_multi;
  logic [WW-1:0]   acc_wait;
  logic            cap;
  logic [IW-1:0]   cap_sel;
  logic            cap_nosel;
  logic            cap_multi;

  io_prio_enc #(
    .N (NCH)
  ) u_prio_enc (
    .vec   (cs),
    .idx   (enc_idx),
    .none  (enc_none),
    .multi (enc_multi)
  );

  // A request with no chip select completes immediately regardless of channel 0's wait.
  assign acc_wait = enc_none ? '0 : WAIT_CFG[enc_idx*WW +: WW];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    nosel_d   = nosel_q;
    multi_d   = multi_q;
    cap       = 1'b0;
    cap_sel   = sel_q;
    cap_nosel = nosel_q;
    cap_multi = multi_q;

    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          sel_d   = enc_idx;
          nosel_d = enc_none;
          multi_d = enc_multi;
          if (acc_wait == '0) begin
            cap       = 1'b1;
            cap_sel   = enc_idx;
            cap_nosel = enc_none;
            cap_multi = enc_multi;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = acc_wait;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - WW'(1);
        if (cnt_q == WW'(1)) begin
          cap     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_data_d   = rd_data_q;
    rd_valid_d  = cap;
    strobe_d    = '0;
    err_nosel_d = cap & cap_nosel;
    err_multi_d = cap & cap_multi;
    if (cap) begin
      rd_data_d = cap_nosel ? '0 : ch_data[cap_sel*DW +: DW];
      for (int i = 0; i < NCH; i++) begin
        strobe_d[i] = !cap_nosel && (cap_sel == IW'(i));
      end
    end
    busy_d       = (state_d == ST_WAIT);
    // A new error outranks a simultaneous clear.
    err_sticky_d = err_nosel_d | err_multi_d | (err_sticky_q & ~err_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      sel_q        <= '0;
      nosel_q      <= 1'b0;
      multi_q      <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
      strobe_q     <= '0;
      err_nosel_q  <= 1'b0;
      err_multi_q  <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sel_q        <= sel_d;
      nosel_q      <= nosel_d;
      multi_q      <= multi_d;
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      busy_q       <= busy_d;
      strobe_q     <= strobe_d;
      err_nosel_q  <= err_nosel_d;
      err_multi_q  <= err_multi_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign busy         = busy_q;
  assign ch_rd_strobe = strobe_q;
  assign err_nosel    = err_nosel_q;
  assign err_multi    = err_multi_q;
  assign err_sticky   = err_sticky_q;

endmodule

// File: tb/tb_io_read_bus.sv
// Bench for io_read_bus: directed scenarios plus randomized reads against a
// transaction-level model (lowest-set-bit select, per-channel wait table).
module tb_io_read_bus;

  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int WW  = 3;
  localparam logic [NCH*WW-1:0] WCFG = {3'd1, 3'd3, 3'd0, 3'd2};

  logic              clk = 1'b0;
  logic              reset;
  logic              rd_req;
  logic [NCH-1:0]    cs;
  logic [NCH*DW-1:0] ch_data;
  logic              err_clr;
  logic [DW-1:0]     rd_data;
  logic              rd_valid;
  logic              busy;
  logic [NCH-1:0]    ch_rd_strobe;
  logic              err_nosel;
  logic              err_multi;
  logic              err_sticky;

  int   checks = 0;
  int   errors = 0;
  logic sticky_exp = 1'b0;
  int   wtab[NCH] = '{2, 0, 3, 1};

  io_read_bus #(
    .NCH      (NCH),
    .DW       (DW),
    .WW       (WW),
    .WAIT_CFG (WCFG)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rd_req       (rd_req),
    .cs           (cs),
    .ch_data      (ch_data),
    .err_clr      (err_clr),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .ch_rd_strobe (ch_rd_strobe),
    .err_nosel    (err_nosel),
    .err_multi    (err_multi),
    .err_sticky   (err_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and update the sticky-error expectation for that edge.
  task automatic step(input bit set_err);
    @(posedge clk);
    #1;
    if (reset)        sticky_exp = 1'b0;
    else if (set_err) sticky_exp = 1'b1;
    else if (err_clr) sticky_exp = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rd_data"}, 32'(rd_data), 32'h0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_strobe"}, 32'(ch_rd_strobe), 32'h0);
    chk({tag, "_err_nosel"}, 32'(err_nosel), 32'h0);
    chk({tag, "_err_multi"}, 32'(err_multi), 32'h0);
    chk({tag, "_err_sticky"}, 32'(err_sticky), 32'h0);
  endtask

  // One read transaction from IDLE; rnd scrambles ch_data every cycle,
  // otherwise d0 is presented at accept and d1 for the rest.
  task automatic do_read(input logic [NCH-1:0] c, input bit rnd,
                         input logic [NCH*DW-1:0] d0, input logic [NCH*DW-1:0] d1);
    int sel = -1;
    int w;
    bit nosel, multi;
    logic [NCH*DW-1:0] at_cap;
    logic [DW-1:0] exp_dat;
    logic [NCH-1:0] exp_stb;
    for (int i = 0; i < NCH; i++) if (c[i] && sel < 0) sel = i;
    nosel = (sel < 0);
    multi = ($countones(c) > 1);
    if (nosel) sel = 0;
    w = nosel ? 0 : wtab[sel];
    rd_req  = 1'b1;
    cs      = c;
    ch_data = rnd ? {$urandom, $urandom} : d0;
    at_cap  = ch_data;
    for (int k = 0; k <= w; k++) begin
      at_cap = ch_data;
      step((k == w) && (nosel || multi));
      rd_req = 1'b0;
      cs     = NCH'($urandom);
      if (k < w) begin
        chk("wait_busy", 32'(busy), 32'h1);
        chk("wait_valid", 32'(rd_valid), 32'h0);
      end else begin
        exp_dat = nosel ? '0 : at_cap[sel*DW +: DW];
        exp_stb = nosel ? '0 : (NCH'(1) << sel);
        chk("rd_valid", 32'(rd_valid), 32'h1);
        chk("busy_at_valid", 32'(busy), 32'h0);
        chk("rd_data", 32'(rd_data), 32'(exp_dat));
        chk("strobe", 32'(ch_rd_strobe), 32'(exp_stb));
        chk("err_nosel", 32'(err_nosel), 32'(nosel));
        chk("err_multi", 32'(err_multi), 32'(multi));
      end
      chk("err_sticky", 32'(err_sticky), 32'(sticky_exp));
      ch_data = rnd ? {$urandom, $urandom} : d1;
    end
    step(1'b0);
    chk("post_valid", 32'(rd_valid), 32'h0);
    chk("post_busy", 32'(busy), 32'h0);
    chk("post_strobe", 32'(ch_rd_strobe), 32'h0);
    chk("post_sticky", 32'(err_sticky), 32'(sticky_exp));
  endtask

  initial begin
    reset   = 1'b1;
    rd_req  = 1'b0;
    cs      = '0;
    ch_data = '0;
    err_clr = 1'b0;
    repeat (2) step(1'b0);
    check_zero("reset");
    reset = 1'b0;
    step(1'b0);
    check_zero("idle");

    // Zero-wait channel, data and strobe next cycle.
    do_read(4'b0010, 1'b0, {16'h0, 16'h0, 16'hA5A5, 16'h0}, {16'h0, 16'h0, 16'hA5A5, 16'h0});
    // Three wait states, data changes during WAIT; capture takes the late value.
    do_read(4'b0100, 1'b0, {16'h0, 16'h1111, 16'h0, 16'h0}, {16'h0, 16'h2222, 16'h0, 16'h0});
    // Overlapping selects: channel 1 wins.
    do_read(4'b1010, 1'b0, {16'h3333, 16'h0, 16'h1234, 16'h0}, {16'h3333, 16'h0, 16'h1234, 16'h0});
    err_clr = 1'b1;
    step(1'b0);
    err_clr = 1'b0;
    chk("sticky_cleared", 32'(err_sticky), 32'h0);
    // No select.
    do_read(4'b0000, 1'b0, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF}, {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF});
    // Error set coincident with clear: set wins, then clear takes effect.
    err_clr = 1'b1;
    do_read(4'b0000, 1'b0, '0, '0);
    err_clr = 1'b0;
    chk("sticky_after_clr", 32'(err_sticky), 32'h0);

    // Held request on a two-wait channel: one completion every three cycles.
    ch_data = {16'h0, 16'h0, 16'h0, 16'hC0DE};
    rd_req  = 1'b1;
    cs      = 4'b0001;
    for (int k = 1; k <= 9; k++) begin
      step(1'b0);
      chk("held_valid", 32'(rd_valid), 32'((k % 3) == 0));
      chk("held_busy", 32'(busy), 32'((k % 3) != 0));
      if ((k % 3) == 0) begin
        chk("held_data", 32'(rd_data), 32'hC0DE);
        chk("held_strobe", 32'(ch_rd_strobe), 32'h1);
      end
    end
    rd_req = 1'b0;
    step(1'b0);
    chk("held_release", 32'(rd_valid), 32'h0);

    // Request pulse while busy is dropped.
    ch_data = {16'h0, 16'h0, 16'h7777, 16'hBEEF};
    rd_req  = 1'b1;
    cs      = 4'b0001;
    step(1'b0);
    cs = 4'b0010;
    chk("drop_busy1", 32'(busy), 32'h1);
    step(1'b0);
    rd_req = 1'b0;
    chk("drop_busy2", 32'(busy), 32'h1);
    chk("drop_novalid", 32'(rd_valid), 32'h0);
    step(1'b0);
    chk("drop_valid", 32'(rd_valid), 32'h1);
    chk("drop_data", 32'(rd_data), 32'hBEEF);
    chk("drop_strobe", 32'(ch_rd_strobe), 32'h1);
    repeat (3) begin
      step(1'b0);
      chk("drop_no_extra", 32'(rd_valid), 32'h0);
      chk("drop_idle_busy", 32'(busy), 32'h0);
    end

    // Reset one cycle into WAIT aborts the read.
    rd_req = 1'b1;
    cs     = 4'b0100;
    step(1'b0);
    rd_req = 1'b0;
    chk("mid_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    step(1'b0);
    check_zero("mid_reset");
    reset = 1'b0;
    repeat (4) begin
      step(1'b0);
      check_zero("after_reset");
    end
    do_read(4'b0001, 1'b0, {16'h0, 16'h0, 16'h0, 16'h4242}, {16'h0, 16'h0, 16'h0, 16'h4343});

    // Randomized reads with occasional clears and idle gaps.
    for (int n = 0; n < 80; n++) begin
      err_clr = ($urandom_range(0, 3) == 0);
      do_read(NCH'($urandom_range(0, 15)), 1'b1, '0, '0);
      err_clr = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        step(1'b0);
        chk("gap_valid", 32'(rd_valid), 32'h0);
        chk("gap_sticky", 32'(err_sticky), 32'(sticky_exp));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
